// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS control pipeline.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
package mips_ctrl_pkg;

  localparam int unsigned CTRL_W = 11;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_W  = 2;

  // Bit positions of each field inside the 11-bit control bundle
  localparam int unsigned B_BRANCH     = 10;
  localparam int unsigned B_JUMP       = 9;
  localparam int unsigned B_REG_DST    = 8;
  localparam int unsigned B_WE_REG     = 7;
  localparam int unsigned B_ALU_SRC    = 6;
  localparam int unsigned B_WE_DM      = 5;
  localparam int unsigned B_DM2REG     = 4;
  localparam int unsigned B_ALU_OP_HI  = 3;
  localparam int unsigned B_ALU_OP_LO  = 2;
  localparam int unsigned B_JAL_WD_SEL = 1;
  localparam int unsigned B_JAL_WA_SEL = 0;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       reg_dst;
    logic       we_reg;
    logic       alu_src;
    logic       we_dm;
    logic       dm2reg;
    logic [1:0] alu_op;
    logic       jal_wd_sel;
    logic       jal_wa_sel;
  } ctrl_t;

  // Destination register selected in ID
  function automatic logic [REG_W-1:0] dest_reg(input ctrl_t c,
                                                input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd);
    if (c.jal_wa_sel)   return REG_RA;
    else if (c.reg_dst) return rd;
    else                return rt;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: ID-stage inputs, per-stage control and hazard outputs.
interface ctrl_pipe_if #(parameter int unsigned CNT_W = 16);
  import mips_ctrl_pkg::*;

  ctrl_t              ctrl_d;
  logic [REG_W-1:0]   rs_d;
  logic [REG_W-1:0]   rt_d;
  logic [REG_W-1:0]   rd_d;
  logic               branch_taken_e;

  ctrl_t              ctrl_e;
  ctrl_t              ctrl_m;
  ctrl_t              ctrl_w;
  logic [REG_W-1:0]   wa_e;
  logic [REG_W-1:0]   wa_m;
  logic [REG_W-1:0]   wa_w;
  logic               stall_f;
  logic               stall_d;
  logic               flush_d;
  logic [FWD_W-1:0]   fwd_a_e;
  logic [FWD_W-1:0]   fwd_b_e;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output ctrl_d, rs_d, rt_d, rd_d, branch_taken_e,
    input  ctrl_e, ctrl_m, ctrl_w, wa_e, wa_m, wa_w,
    input  stall_f, stall_d, flush_d, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  ctrl_d, rs_d, rt_d, rd_d, branch_taken_e,
    output ctrl_e, ctrl_m, ctrl_w, wa_e, wa_m, wa_w,
    output stall_f, stall_d, flush_d, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_unit.sv
// Combinational hazard detection and EX operand forwarding select.
// FORWARDING_EN selects bypassing; otherwise any in-flight RAW dependency stalls.
module hazard_unit
  import mips_ctrl_pkg::*;
(
  input  ctrl_t            ctrl_d_i,
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  ctrl_t            ctrl_e_i,
  input  logic [REG_W-1:0] wa_e_i,
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rt_e_i,
  input  ctrl_t            ctrl_m_i,
  input  logic [REG_W-1:0] wa_m_i,
  input  ctrl_t            ctrl_w_i,
  input  logic [REG_W-1:0] wa_w_i,
  input  logic             branch_taken_e_i,
  output logic             stall_c_o,
  output logic             flush_c_o,
  output logic             bubble_c_o,
  output logic [FWD_W-1:0] fwd_a_c_o,
  output logic [FWD_W-1:0] fwd_b_c_o
);

  logic load_use_c;
  logic raw_c;
  logic hazard_c;
  logic unused_c;

`ifdef FORWARDING_EN
  // MEM has priority over WB since it holds the younger result
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (ctrl_m_i.we_reg && (wa_m_i != '0) && (wa_m_i == src))      return FWD_MEM;
    else if (ctrl_w_i.we_reg && (wa_w_i != '0) && (wa_w_i == src)) return FWD_WB;
    else                                                           return FWD_RF;
  endfunction
`else
  function automatic logic src_hit(input logic [REG_W-1:0] src);
    return (src != '0) &&
           ((ctrl_e_i.we_reg && (wa_e_i == src)) ||
            (ctrl_m_i.we_reg && (wa_m_i == src)));
  endfunction
`endif

  always_comb begin
    raw_c     = 1'b0;
    fwd_a_c_o = FWD_RF;
    fwd_b_c_o = FWD_RF;

    load_use_c = ctrl_e_i.dm2reg && ctrl_e_i.we_reg && (wa_e_i != '0) &&
                 ((wa_e_i == rs_d_i) || (wa_e_i == rt_d_i));
`ifdef FORWARDING_EN
    fwd_a_c_o = fwd_sel(rs_e_i);
    fwd_b_c_o = fwd_sel(rt_e_i);
`else
    raw_c = src_hit(rs_d_i) || src_hit(rt_d_i);
`endif
    hazard_c = load_use_c || raw_c;

    // A taken branch squashes the ID instruction, so there is nothing to hold
    stall_c_o  = hazard_c && !branch_taken_e_i;
    bubble_c_o = hazard_c || branch_taken_e_i;
    flush_c_o  = branch_taken_e_i || (ctrl_d_i.jump && !stall_c_o);
  end

  assign unused_c = ^{ctrl_d_i, ctrl_e_i, ctrl_m_i, ctrl_w_i, rs_e_i, rt_e_i, wa_w_i};

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with hazard handling and event counters.
// Define FORWARDING_EN to enable EX operand forwarding.
module ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  ctrl_t            ctrl_e_q, ctrl_e_d, ctrl_m_q, ctrl_w_q;
  logic [REG_W-1:0] wa_e_q, wa_e_d, wa_m_q, wa_w_q;
  logic [REG_W-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [REG_W-1:0] wa_d;
  logic             stall_c, flush_c, bubble_c;
  logic [FWD_W-1:0] fwd_a_c, fwd_b_c;

  hazard_unit u_hazard (
    .ctrl_d_i         (bus.ctrl_d),
    .rs_d_i           (bus.rs_d),
    .rt_d_i           (bus.rt_d),
    .ctrl_e_i         (ctrl_e_q),
    .wa_e_i           (wa_e_q),
    .rs_e_i           (rs_e_q),
    .rt_e_i           (rt_e_q),
    .ctrl_m_i         (ctrl_m_q),
    .wa_m_i           (wa_m_q),
    .ctrl_w_i         (ctrl_w_q),
    .wa_w_i           (wa_w_q),
    .branch_taken_e_i (bus.branch_taken_e),
    .stall_c_o        (stall_c),
    .flush_c_o        (flush_c),
    .bubble_c_o       (bubble_c),
    .fwd_a_c_o        (fwd_a_c),
    .fwd_b_c_o        (fwd_b_c)
  );

  assign wa_d = dest_reg(bus.ctrl_d, bus.rt_d, bus.rd_d);

  // ID/EX next state and saturating counters
  always_comb begin
    ctrl_e_d    = bus.ctrl_d;
    wa_e_d      = wa_d;
    rs_e_d      = bus.rs_d;
    rt_e_d      = bus.rt_d;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bubble_c) begin
      ctrl_e_d = '0;
      wa_e_d   = '0;
      rs_e_d   = '0;
      rt_e_d   = '0;
    end
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e_q    <= '0;
      ctrl_m_q    <= '0;
      ctrl_w_q    <= '0;
      wa_e_q      <= '0;
      wa_m_q      <= '0;
      wa_w_q      <= '0;
      rs_e_q      <= '0;
      rt_e_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_e_q    <= ctrl_e_d;
      ctrl_m_q    <= ctrl_e_q;
      ctrl_w_q    <= ctrl_m_q;
      wa_e_q      <= wa_e_d;
      wa_m_q      <= wa_e_q;
      wa_w_q      <= wa_m_q;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ctrl_e    = ctrl_e_q;
  assign bus.ctrl_m    = ctrl_m_q;
  assign bus.ctrl_w    = ctrl_w_q;
  assign bus.wa_e      = wa_e_q;
  assign bus.wa_m      = wa_m_q;
  assign bus.wa_w      = wa_w_q;
  assign bus.stall_f   = stall_c;
  assign bus.stall_d   = stall_c;
  assign bus.flush_d   = flush_c;
  assign bus.fwd_a_e   = fwd_a_c;
  assign bus.fwd_b_e   = fwd_b_c;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations are hand-derived instruction bundles.
// Forwarding checks are compiled in when FORWARDING_EN is defined.
module tb_ctrl_pipe;
  import mips_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;

  // {branch,jump,reg_dst,we_reg,alu_src,we_dm,dm2reg,alu_op[1:0],jal_wd_sel,jal_wa_sel}
  localparam logic [10:0] NOP = 11'h000;
  localparam logic [10:0] LW  = 11'h0D0;
  localparam logic [10:0] ADD = 11'h188;
  localparam logic [10:0] JAL = 11'h283;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic bt);
    bus.ctrl_d         = ctrl_t'(c);
    bus.rs_d           = rs;
    bus.rt_d           = rt;
    bus.rd_d           = rd;
    bus.branch_taken_e = bt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;

    // Reset state
    do_reset();
    #1;
    check("rst_ctrl_e", 32'(bus.ctrl_e), 32'(NOP));
    check("rst_ctrl_m", 32'(bus.ctrl_m), 32'(NOP));
    check("rst_ctrl_w", 32'(bus.ctrl_w), 32'(NOP));
    check("rst_wa_e", 32'(bus.wa_e), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("rst_stall_d", 32'(bus.stall_d), 32'd0);
    check("rst_flush_d", 32'(bus.flush_d), 32'd0);
    check("rst_fwd_a", 32'(bus.fwd_a_e), 32'd0);

    // Latency 1/2/3 cycles
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    check("lat_ctrl_e", 32'(bus.ctrl_e), 32'(ADD));
    check("lat_wa_e", 32'(bus.wa_e), 32'd9);
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check("lat_ctrl_m", 32'(bus.ctrl_m), 32'(ADD));
    check("lat_wa_m", 32'(bus.wa_m), 32'd9);
    check("lat_ctrl_e_nop", 32'(bus.ctrl_e), 32'(NOP));
    tick();
    check("lat_ctrl_w", 32'(bus.ctrl_w), 32'(ADD));
    check("lat_wa_w", 32'(bus.wa_w), 32'd9);

    // Load-use: LW $8 in EX, consumer reads $8 via rs
    do_reset();
    drive(LW, 5'd0, 5'd8, 5'd0, 1'b0);
    tick();
    check("lu_ctrl_e", 32'(bus.ctrl_e), 32'(LW));
    check("lu_wa_e", 32'(bus.wa_e), 32'd8);
    drive(ADD, 5'd8, 5'd3, 5'd10, 1'b0);
    #1;
    check("lu_stall_d", 32'(bus.stall_d), 32'd1);
    check("lu_stall_f", 32'(bus.stall_f), 32'd1);
    check("lu_flush_d", 32'(bus.flush_d), 32'd0);
    tick();
    check("lu_bubble", 32'(bus.ctrl_e), 32'(NOP));
    check("lu_ctrl_m", 32'(bus.ctrl_m), 32'(LW));
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    #1;
`ifdef FORWARDING_EN
    check("lu_one_cycle", 32'(bus.stall_d), 32'd0);
    tick();
    check("lu_add_in_e", 32'(bus.ctrl_e), 32'(ADD));
    check("lu_stall_cnt2", 32'(bus.stall_cnt), 32'd1);
`else
    check("lu_mem_stall", 32'(bus.stall_d), 32'd1);
    tick();
    check("lu_bubble2", 32'(bus.ctrl_e), 32'(NOP));
    check("lu_stall_cnt2", 32'(bus.stall_cnt), 32'd2);
`endif
    #1;
    check("wb_no_stall", 32'(bus.stall_d), 32'd0);

    // JAL in ID
    do_reset();
    drive(JAL, 5'd0, 5'd0, 5'd5, 1'b0);
    #1;
    check("jal_flush_d", 32'(bus.flush_d), 32'd1);
    check("jal_stall_d", 32'(bus.stall_d), 32'd0);
    tick();
    check("jal_wa_e", 32'(bus.wa_e), 32'd31);
    check("jal_wd_sel", 32'(bus.ctrl_e.jal_wd_sel), 32'd1);
    check("jal_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // Taken branch overrides a simultaneous load-use stall
    do_reset();
    drive(LW, 5'd0, 5'd8, 5'd0, 1'b0);
    tick();
    drive(ADD, 5'd8, 5'd3, 5'd10, 1'b1);
    #1;
    check("br_stall_d", 32'(bus.stall_d), 32'd0);
    check("br_stall_f", 32'(bus.stall_f), 32'd0);
    check("br_flush_d", 32'(bus.flush_d), 32'd1);
    tick();
    check("br_bubble", 32'(bus.ctrl_e), 32'(NOP));
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Taken branch squashes a jump in ID
    do_reset();
    drive(JAL, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("sq_flush_d", 32'(bus.flush_d), 32'd1);
    tick();
    check("sq_ctrl_e", 32'(bus.ctrl_e), 32'(NOP));
    check("sq_wa_e", 32'(bus.wa_e), 32'd0);
    check("sq_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // $0 is never a hazard source
    do_reset();
    drive(LW, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(ADD, 5'd0, 5'd5, 5'd3, 1'b0);
    #1;
    check("r0_lu_stall", 32'(bus.stall_d), 32'd0);
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(ADD, 5'd0, 5'd0, 5'd11, 1'b0);
    #1;
    check("r0_raw_stall", 32'(bus.stall_d), 32'd0);

`ifdef FORWARDING_EN
    // Back-to-back dependency forwards from MEM
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(ADD, 5'd9, 5'd3, 5'd10, 1'b0);
    #1;
    check("fw_no_stall", 32'(bus.stall_d), 32'd0);
    tick();
    check("fw_a_mem", 32'(bus.fwd_a_e), 32'(FWD_MEM));
    check("fw_b_rf", 32'(bus.fwd_b_e), 32'(FWD_RF));
    // One intervening instruction forwards from WB
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(ADD, 5'd9, 5'd3, 5'd10, 1'b0);
    tick();
    check("fw_a_wb", 32'(bus.fwd_a_e), 32'(FWD_WB));
    // rt operand
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(ADD, 5'd4, 5'd9, 5'd10, 1'b0);
    tick();
    check("fw_b_mem", 32'(bus.fwd_b_e), 32'(FWD_MEM));
    check("fw_a_rf", 32'(bus.fwd_a_e), 32'(FWD_RF));
    // $0 dependency never forwards
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(ADD, 5'd0, 5'd3, 5'd10, 1'b0);
    tick();
    check("fw_r0", 32'(bus.fwd_a_e), 32'(FWD_RF));
`else
    // Without bypassing, an ALU dependency on EX stalls and fwd stays 00
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(ADD, 5'd0, 5'd9, 5'd12, 1'b0);
    #1;
    check("nf_raw_stall", 32'(bus.stall_d), 32'd1);
    tick();
    check("nf_bubble", 32'(bus.ctrl_e), 32'(NOP));
    check("nf_fwd_a", 32'(bus.fwd_a_e), 32'd0);
    check("nf_fwd_b", 32'(bus.fwd_b_e), 32'd0);
`endif

    // Stall counter saturation: at least one stall per iteration, 2^CNT_W+3 iterations
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(LW, 5'd0, 5'd8, 5'd0, 1'b0);
      tick();
      drive(ADD, 5'd8, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check("sat_stall_cnt", 32'(bus.stall_cnt), 32'hF);

    // Flush counter saturation
    do_reset();
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b1);
    repeat ((1 << CNT_W) + 3) tick();
    check("sat_flush_cnt", 32'(bus.flush_cnt), 32'hF);
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);

    // Mid-stream reset discards in-flight control
    do_reset();
    drive(ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(LW, 5'd0, 5'd8, 5'd0, 1'b0);
    tick();
    drive(JAL, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    check("pre_rst_ctrl_w", 32'(bus.ctrl_w), 32'(ADD));
    check("pre_rst_ctrl_m", 32'(bus.ctrl_m), 32'(LW));
    rst = 1'b1;
    tick();
    check("mid_rst_ctrl_e", 32'(bus.ctrl_e), 32'(NOP));
    check("mid_rst_ctrl_m", 32'(bus.ctrl_m), 32'(NOP));
    check("mid_rst_ctrl_w", 32'(bus.ctrl_w), 32'(NOP));
    check("mid_rst_wa_e", 32'(bus.wa_e), 32'd0);
    check("mid_rst_wa_m", 32'(bus.wa_m), 32'd0);
    check("mid_rst_wa_w", 32'(bus.wa_w), 32'd0);
    check("mid_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("mid_rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    rst = 1'b0;
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("post_rst_stall_d", 32'(bus.stall_d), 32'd0);
    check("post_rst_flush_d", 32'(bus.flush_d), 32'd0);
    check("post_rst_fwd_a", 32'(bus.fwd_a_e), 32'd0);
    check("post_rst_fwd_b", 32'(bus.fwd_b_e), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
